// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The producer/consumer side uses the master modport and the arithmetic unit uses the slave modport.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, x, y, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, x, y, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: one SEG-bit slice per stage with the carry rippling between stages.
// Operands are skewed in and result slices are deskewed out, so s/co/ovf leave aligned after STAGES cycles.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0) begin : g_bad_seg
    $error("pipelined_addsub: WIDTH must be a multiple of SEG");
  end

  // Bank k feeds stage k; bank STAGES holds the finished result.
  logic [WIDTH-1:0] opx_q [STAGES];
  logic [WIDTH-1:0] opx_d [STAGES];
  logic [WIDTH-1:0] opy_q [STAGES];
  logic [WIDTH-1:0] opy_d [STAGES];
  logic [WIDTH-1:0] acc_q [STAGES+1];
  logic [WIDTH-1:0] acc_d [STAGES+1];
  logic             cy_q  [STAGES+1];
  logic             cy_d  [STAGES+1];
  logic             vld_q [STAGES+1];
  logic             vld_d [STAGES+1];
  logic             ovf_q;
  logic             ovf_d;
  logic [SEG:0]     slice_s;
  logic             stall_s;
  logic             adv_s;

  assign stall_s       = vld_q[STAGES] & ~bus.out_ready;
  assign adv_s         = ~stall_s;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = vld_q[STAGES];
  assign bus.s         = acc_q[STAGES];
  assign bus.co        = cy_q[STAGES];
  assign bus.ovf       = ovf_q;

  // Next-state of every bank: capture operands, add one slice per stage, shift everything forward.
  always_comb begin
    opx_d[0] = bus.x;
    if (bus.sub) begin
      opy_d[0] = ~bus.y;
    end else begin
      opy_d[0] = bus.y;
    end
    acc_d[0] = {WIDTH{1'b0}};
    cy_d[0]  = bus.ci ^ bus.sub;
    vld_d[0] = bus.in_valid;
    slice_s  = {(SEG+1){1'b0}};

    for (int k = 1; k < STAGES; k++) begin
      opx_d[k] = opx_q[k-1];
      opy_d[k] = opy_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      slice_s = {1'b0, opx_q[k][k*SEG +: SEG]} + {1'b0, opy_q[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, cy_q[k]};
      acc_d[k+1]                = acc_q[k];
      acc_d[k+1][k*SEG +: SEG]  = slice_s[SEG-1:0];
      cy_d[k+1]                 = slice_s[SEG];
      vld_d[k+1]                = vld_q[k];
    end

    // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
    ovf_d = opx_q[STAGES-1][WIDTH-1] ^ opy_q[STAGES-1][WIDTH-1]
          ^ acc_d[STAGES][WIDTH-1] ^ cy_d[STAGES];
  end

  // All banks advance together unless the result bank is held by backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        opx_q[k] <= {WIDTH{1'b0}};
        opy_q[k] <= {WIDTH{1'b0}};
      end
      for (int k = 0; k <= STAGES; k++) begin
        acc_q[k] <= {WIDTH{1'b0}};
        cy_q[k]  <= 1'b0;
        vld_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        opx_q[k] <= opx_d[k];
        opy_q[k] <= opy_d[k];
      end
      for (int k = 0; k <= STAGES; k++) begin
        acc_q[k] <= acc_d[k];
        cy_q[k]  <= cy_d[k];
        vld_q[k] <= vld_d[k];
      end
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, SEG=4): directed corner cases, stall,
// mid-flight reset and a randomized stream, all checked against an arithmetic reference model.
module tb_pipelined_addsub;
  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int LAT   = WIDTH / SEG;

  typedef struct {
    logic [17:0] res;
    int          rem;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   or_mode;
  ent_t q[$];
  ent_t e;
  logic exp_ov;
  logic exp_ir;

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Consumer: out_ready always high, random, or forced low.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Reference: {co, ovf, s} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic sb);
    int ua, ub, sa, sbv, ci_i, r, sr;
    logic co_m, ovf_m;
    logic [15:0] s_m;
    ua   = int'(a);
    ub   = int'(b);
    sa   = int'($signed(a));
    sbv  = int'($signed(b));
    ci_i = c ? 1 : 0;
    if (!sb) begin
      r    = ua + ub + ci_i;
      sr   = sa + sbv + ci_i;
      co_m = (r > 65535);
    end else begin
      r    = ua - ub - ci_i;
      sr   = sa - sbv - ci_i;
      co_m = (r >= 0);
    end
    s_m   = r[15:0];
    ovf_m = (sr > 32767) || (sr < -32768);
    return {co_m, ovf_m, s_m};
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic pin(input string nm, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_%s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb);
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.ci = c;
    bus.sub = sb;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout got in_ready=0 for 200 cycles exp accept");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending exp 0", q.size());
    end
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    or_mode = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = 16'h0000;
    bus.y = 16'h0000;
    bus.ci = 1'b0;
    bus.sub = 1'b0;

    // Compare process: cycle-level expectations from the in-flight queue.
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          checks++;
          if (bus.out_valid !== 1'b0 || bus.s !== 16'h0000 || bus.co !== 1'b0 ||
              bus.ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got ov=%0b s=%h co=%0b ovf=%0b ir=%0b exp ov=0 s=0000 co=0 ovf=0 ir=1",
                     bus.out_valid, bus.s, bus.co, bus.ovf, bus.in_ready);
          end
          q.delete();
        end else begin
          exp_ov = (q.size() > 0) && (q[0].rem == 0);
          exp_ir = !(exp_ov && !bus.out_ready);
          checks++;
          if (bus.out_valid !== exp_ov) begin
            errors++;
            $display("FAIL out_valid got %0b exp %0b", bus.out_valid, exp_ov);
          end
          checks++;
          if (bus.in_ready !== exp_ir) begin
            errors++;
            $display("FAIL in_ready got %0b exp %0b", bus.in_ready, exp_ir);
          end
          if (exp_ov) begin
            checks++;
            if ({bus.co, bus.ovf, bus.s} !== q[0].res) begin
              errors++;
              $display("FAIL result got co=%0b ovf=%0b s=%h exp co=%0b ovf=%0b s=%h",
                       bus.co, bus.ovf, bus.s, q[0].res[17], q[0].res[16], q[0].res[15:0]);
            end
          end
          if (exp_ir) begin
            if (exp_ov) begin
              void'(q.pop_front());
            end
            for (int i = 0; i < q.size(); i++) begin
              if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
            end
            if (bus.in_valid) begin
              e.res = model(bus.x, bus.y, bus.ci, bus.sub);
              e.rem = LAT;
              q.push_back(e);
            end
          end
        end
      end
    join_none

    // Hand-computed values that pin the reference model.
    pin("add_ffff_1", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), {1'b1, 1'b0, 16'h0000});
    pin("add_7fff_1", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {1'b0, 1'b1, 16'h8000});
    pin("sub_5_7",    model(16'h0005, 16'h0007, 1'b0, 1'b1), {1'b0, 1'b0, 16'hFFFE});
    pin("sub_8000_1", model(16'h8000, 16'h0001, 1'b0, 1'b1), {1'b1, 1'b1, 16'h7FFF});
    pin("sub_3_1_b",  model(16'h0003, 16'h0001, 1'b1, 1'b1), {1'b1, 1'b0, 16'h0001});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Latency of a single add on an idle pipe.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL latency got %0d exp 4", cyc);
    end
    drain();

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0003, 16'h0001, 1'b1, 1'b1);
    drain();

    // Eight back-to-back vectors with a three-cycle consumer stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1 or_mode = 2;
        repeat (3) @(posedge clk);
        #1 or_mode = 0;
      end
    join
    drain();

    // Reset with three results in flight; the next vector must be the next result.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0);
    send(16'h5555, 16'h0001, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush got out_valid=%0b exp 0", bus.out_valid);
    end
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(16'h00A5, 16'h005A, 1'b1, 1'b0);
    drain();

    // Randomized stream with random backpressure and input gaps.
    or_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #1 or_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
